// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmio_uart_pkg;

    // Serialiser states; one frame walks START -> DATA -> STOP.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Bit positions inside the status word returned on loads.
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_OVF     = 2;
    localparam int unsigned STAT_CNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
// Latency: a pushed word is visible on dout_o the cycle after the push edge.
// Backpressure: push while full is refused unless a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping processor stores; status word on loads.
// Latency: first start bit appears on tx one cycle after the store edge; frame is 10*CLKS_PER_BIT.
// Backpressure: none to the CPU; stores to a full FIFO are dropped and flagged as sticky overflow.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_0104,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] StatusData,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;

    uart_state_t       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;

    logic              push;
    logic              pop;
    logic              ovf_clr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              baud_done;
    logic [31:0]       status;
    logic              unused_wdata;

    // Only the low byte (TX) and bit 2 (overflow clear) of the store data matter.
    assign unused_wdata = ^{WriteData[31:8], WriteData[7:3], WriteData[1:0]};

    assign push    = MemWrite && (DataAdr == TX_ADDR);
    assign ovf_clr = MemWrite && (DataAdr == STAT_ADDR) && WriteData[2];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (WriteData[7:0]),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    // Overflow is sticky; a drop on the same edge as a clear wins.
    always_comb begin
        ovf_d = (ovf_q && !ovf_clr) || (push && fifo_full && !pop);
    end

    // Serialiser next-state: pop/load, bit stepping, baud reload on state change.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) state_d = DATA;
            end
            DATA: begin
                if (baud_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)  baud_d = '0;
        else if (state_q != IDLE) baud_d = baud_done ? '0 : baud_q + BAUD_W'(1);

        // tx is registered, so it is derived from where the FSM is heading.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Serialiser and flag registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) || (fifo_count != '0);

    // Status word assembly; only driven when the status address is on the bus.
    always_comb begin
        status                      = '0;
        status[STAT_BUSY]           = busy;
        status[STAT_FULL]           = fifo_full;
        status[STAT_OVF]            = ovf_q;
        status[STAT_CNT_LSB +: 4]   = 4'(fifo_count);
        StatusData                  = (DataAdr == STAT_ADDR) ? status : 32'h0;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam logic [31:0] TXA  = 32'h0000_0100;
    localparam logic [31:0] STA  = 32'h0000_0104;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] StatusData;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    mmio_uart_tx #(
        .TX_ADDR      (TXA),
        .STAT_ADDR    (STA),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .StatusData (StatusData),
        .tx         (tx),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rd_adr;
        logic [31:0] exp_stat;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [119:0] act, input logic [119:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected tx samples of one 8N1 frame at 4 clocks/bit, index 0 = first start-bit cycle.
    function automatic logic [39:0] frame(input logic [7:0] d);
        logic [39:0] f;
        for (int k = 0; k < 40; k++) begin
            int b;
            b = k / 4;
            if (b == 0)      f[k] = 1'b0;
            else if (b <= 8) f[k] = d[b-1];
            else             f[k] = 1'b1;
        end
        return f;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] dat);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = dat;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic capture(input int n, output logic [119:0] rec);
        rec = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rec[k] = tx;
        end
    endtask

    logic [119:0] rec;

    initial begin
        // Overflow / status / decode sequence, one store per cycle while a frame runs.
        tbl[0]  = '{1'b1, TXA, 32'h11,        STA,   32'h11};
        tbl[1]  = '{1'b1, TXA, 32'h22,        STA,   32'h11};
        tbl[2]  = '{1'b1, TXA, 32'h33,        STA,   32'h21};
        tbl[3]  = '{1'b1, TXA, 32'h44,        STA,   32'h31};
        tbl[4]  = '{1'b1, TXA, 32'h55,        STA,   32'h43};
        tbl[5]  = '{1'b1, TXA, 32'h66,        STA,   32'h47};
        tbl[6]  = '{1'b1, STA, 32'h4,         STA,   32'h43};
        tbl[7]  = '{1'b1, 32'h108, 32'hAB,    STA,   32'h43};
        tbl[8]  = '{1'b1, TXA, 32'h99,        STA,   32'h47};
        tbl[9]  = '{1'b1, STA, 32'hFFFF_FFFB, STA,   32'h47};
        tbl[10] = '{1'b0, STA, 32'h4,         TXA,   32'h0};
        tbl[11] = '{1'b1, STA, 32'h4,         STA,   32'h43};

        do_reset();

        // Reset state
        DataAdr = STA;
        #1;
        chk("reset_tx", 120'(tx), 120'(1'b1));
        chk("reset_busy", 120'(busy), 120'(1'b0));
        chk("reset_status", 120'(StatusData), 120'(32'h0));

        // Single byte 0xA5
        store(TXA, 32'h0000_00A5);
        chk("single_tx_at_store_edge", 120'(tx), 120'(1'b1));
        chk("single_busy_queued", 120'(busy), 120'(1'b1));
        capture(40, rec);
        chk("single_frame", rec, 120'(frame(8'hA5)));
        @(posedge clk); #1;
        chk("single_done_busy_tx", 120'({busy, tx}), 120'(2'b01));

        // Low-byte masking and ignored address
        store(TXA, 32'h1234_5678);
        capture(40, rec);
        chk("mask_frame", rec, 120'(frame(8'h78)));
        @(posedge clk); #1;
        store(32'h108, 32'h0000_00C3);
        DataAdr = STA;
        #1;
        chk("ignore_status", 120'(StatusData), 120'(32'h0));
        repeat (3) @(posedge clk);
        #1;
        chk("ignore_idle_busy_tx", 120'({busy, tx}), 120'(2'b01));

        // Back-to-back frames with status reads mid-stream
        do_reset();
        store(TXA, 32'h01);
        fork
            capture(120, rec);
            begin
                MemWrite = 1'b1; DataAdr = TXA; WriteData = 32'h02;
                @(posedge clk); #1;
                WriteData = 32'h03;
                @(posedge clk); #1;
                MemWrite = 1'b0; DataAdr = STA; WriteData = 32'h0;
                #1;
                chk("b2b_status_two_queued", 120'(StatusData), 120'(32'h21));
                DataAdr = TXA;
                #1;
                chk("b2b_status_other_addr", 120'(StatusData), 120'(32'h0));
                DataAdr = 32'h0;
            end
        join
        chk("b2b_frames", rec, {frame(8'h03), frame(8'h02), frame(8'h01)});
        @(posedge clk); #1;
        chk("b2b_done_busy_tx", 120'({busy, tx}), 120'(2'b01));

        // Table: overflow, clear, decode
        do_reset();
        for (int i = 0; i < 12; i++) begin
            MemWrite  = tbl[i].we;
            DataAdr   = tbl[i].adr;
            WriteData = tbl[i].wdat;
            @(posedge clk); #1;
            MemWrite  = 1'b0;
            WriteData = 32'h0;
            DataAdr   = tbl[i].rd_adr;
            #1;
            chk($sformatf("tbl_status_%0d", i), 120'(StatusData), 120'(tbl[i].exp_stat));
        end

        // Reset during data bit 3 with a byte still queued
        do_reset();
        store(TXA, 32'h3C);
        store(TXA, 32'h11);
        repeat (17) @(posedge clk);
        #1;
        chk("midframe_tx_bit3", 120'(tx), 120'(1'b1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        DataAdr = STA;
        #1;
        chk("midreset_busy_tx", 120'({busy, tx}), 120'(2'b01));
        chk("midreset_status", 120'(StatusData), 120'(32'h0));
        store(TXA, 32'h5A);
        capture(40, rec);
        chk("post_reset_frame", rec, 120'(frame(8'h5A)));
        @(posedge clk); #1;
        chk("post_reset_idle", 120'({busy, tx}), 120'(2'b01));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
